ifetch_axi: RTL and testbench

IFETCH_AXI -- requirements
Module: ifetch_axi

---
 rtl/ifetch_axi.sv | 185 ++++++++++++++++++
 tb/tb_ifetch_axi.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_axi.sv
// rtl/ifetch_axi.sv - single-outstanding AXI4 instruction fetcher feeding an instruction queue
// Redirect, start and hold_reset all flush the queue; an in-flight read is drained and discarded.
module ifetch_axi #(
   parameter int QDEPTH = 4
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic        start,
   input  logic        hold_reset,
   input  logic [31:0] dram_base,
   input  logic [31:0] entry_pc,
   input  logic        redir_valid,
   input  logic [31:0] redir_pc,
   output logic [31:0] ARADDR,
   output logic        ARVALID,
   input  logic        ARREADY,
   output logic [7:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic        RVALID,
   output logic        RREADY,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_data,
   output logic        inst_err,
   output logic [31:0] last_pc
);
   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0] QFULL = (AW + 1)'(QDEPTH);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_HALT} state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   araddr_q, araddr_d;
   logic [31:0]   ar_pc_q, ar_pc_d;
   logic [31:0]   last_pc_q, last_pc_d;
   logic          run_q, run_d;
   logic          drain_pend_q, drain_pend_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   logic [31:0]   mem_pc   [QDEPTH];
   logic [31:0]   mem_data [QDEPTH];
   logic          mem_err  [QDEPTH];

   logic          redir_any, flush, fetch_en, ar_hs, r_hs, pop, push, push_err;
   logic [31:0]   redir_tgt;
   logic          unused_rlast;

   // Every read is a single beat, so RLAST carries no information.
   assign unused_rlast = RLAST;

   assign ARLEN      = 8'd0;
   assign ARSIZE     = 3'b010;
   assign ARBURST    = 2'b01;
   assign ARVALID    = (state_q == S_ADDR);
   assign ARADDR     = araddr_q;
   assign RREADY     = (state_q == S_DATA) || (state_q == S_DRAIN);
   assign inst_valid = (count_q != '0);
   assign inst_pc    = inst_valid ? mem_pc[rd_ptr_q]   : 32'd0;
   assign inst_data  = inst_valid ? mem_data[rd_ptr_q] : 32'd0;
   assign inst_err   = inst_valid ? mem_err[rd_ptr_q]  : 1'b0;
   assign last_pc    = last_pc_q;

   always_comb begin
      redir_any    = redir_valid | start;
      redir_tgt    = redir_valid ? redir_pc : entry_pc;
      flush        = redir_any | hold_reset;
      fetch_en     = run_q & ~hold_reset;
      ar_hs        = ARVALID & ARREADY;
      r_hs         = RREADY & RVALID;
      pop          = inst_valid & inst_ready;
      push_err     = (RRESP != 2'b00);
      push         = 1'b0;
      state_d      = state_q;
      pc_d         = redir_any ? redir_tgt : pc_q;
      araddr_d     = araddr_q;
      ar_pc_d      = ar_pc_q;
      drain_pend_d = drain_pend_q;
      run_d        = hold_reset ? 1'b0 : (redir_any ? 1'b1 : run_q);

      case (state_q)
         S_IDLE: begin
            if (!flush && fetch_en && (count_q < QFULL)) begin
               state_d  = S_ADDR;
               araddr_d = (dram_base + pc_q) & 32'hFFFF_FFFC;
               ar_pc_d  = pc_q;
            end
         end
         S_ADDR: begin
            // A flush while ARVALID is up cannot retract the request; remember it and drain later.
            if (ar_hs) begin
               drain_pend_d = 1'b0;
               if (flush || drain_pend_q) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_DATA;
                  pc_d    = pc_q + 32'd4;
               end
            end else if (flush) begin
               drain_pend_d = 1'b1;
            end
         end
         S_DATA: begin
            if (r_hs) begin
               if (flush) begin
                  state_d = S_IDLE;
               end else begin
                  push    = 1'b1;
                  state_d = push_err ? S_HALT : S_IDLE;
               end
            end else if (flush) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_hs) state_d = S_IDLE;
         end
         S_HALT: begin
            if (flush) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      last_pc_d = pop ? mem_pc[rd_ptr_q] : last_pc_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q      <= S_IDLE;
         pc_q         <= 32'd0;
         araddr_q     <= 32'd0;
         ar_pc_q      <= 32'd0;
         last_pc_q    <= 32'd0;
         run_q        <= 1'b0;
         drain_pend_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         araddr_q     <= araddr_d;
         ar_pc_q      <= ar_pc_d;
         last_pc_q    <= last_pc_d;
         run_q        <= run_d;
         drain_pend_q <= drain_pend_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Storage is not reset; outputs are masked by inst_valid while the queue is empty.
   always_ff @(posedge ACLK) begin
      if (push) begin
         mem_pc[wr_ptr_q]   <= ar_pc_q;
         mem_data[wr_ptr_q] <= RDATA;
         mem_err[wr_ptr_q]  <= push_err;
      end
   end

endmodule

// File: tb/tb_ifetch_axi.sv
// tb/tb_ifetch_axi.sv - self-checking bench for ifetch_axi with an AXI slave and queue reference model
module tb_ifetch_axi;
   localparam int QDEPTH = 4;

   logic        ACLK = 1'b0;
   logic        ARESETN, start, hold_reset, redir_valid;
   logic [31:0] dram_base, entry_pc, redir_pc;
   logic [31:0] ARADDR;
   logic        ARVALID, ARREADY;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST, RVALID, RREADY;
   logic        inst_valid, inst_ready, inst_err;
   logic [31:0] inst_pc, inst_data, last_pc;

   always #5 ACLK = ~ACLK;

   ifetch_axi #(.QDEPTH(QDEPTH)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .hold_reset(hold_reset),
      .dram_base(dram_base), .entry_pc(entry_pc), .redir_valid(redir_valid), .redir_pc(redir_pc),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
      .RREADY(RREADY), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
      .inst_data(inst_data), .inst_err(inst_err), .last_pc(last_pc)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic        err;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] pop_pc[$], pop_data[$], ar_log[$];
   int          n_vec = 0, n_err = 0;
   logic [31:0] mpc, mlast, m_ar_addr, m_ar_pc, s_addr, err_addr;
   bit          m_run, m_halt, m_out, m_ar_pend, m_doom, m_may, s_busy;
   int          s_dly, ar_pct, rdy_mode, r_lo, r_hi, ar_cnt;

   task automatic chk1(input string tag, input logic obs, input logic expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Slave memory: the first eight words above dram_base hold 0x11..0x18.
   function automatic logic [31:0] slave_word(input logic [31:0] a);
      logic [31:0] idx;
      idx = (a - dram_base) >> 2;
      return (idx < 32'd8) ? 32'h11 + idx : a ^ 32'h5A5A_5A5A;
   endfunction

   task automatic model_reset();
      mq.delete();
      mpc = 0; mlast = 0; m_run = 0; m_halt = 0; m_out = 0;
      m_ar_pend = 0; m_doom = 0; m_may = 0; s_busy = 0; RVALID = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk1({tag, "_arvalid"}, ARVALID, 1'b0);
      chk1({tag, "_rready"}, RREADY, 1'b0);
      chk1({tag, "_inst_valid"}, inst_valid, 1'b0);
      chk1({tag, "_inst_err"}, inst_err, 1'b0);
      chk32({tag, "_last_pc"}, last_pc, 32'd0);
      chk32({tag, "_inst_pc"}, inst_pc, 32'd0);
      chk32({tag, "_inst_data"}, inst_data, 32'd0);
   endtask

   // One clock: drive slave/consumer inputs, check against the model, advance the model.
   task automatic tick();
      bit          flush, redir_any, ar_hs, r_hs, pop, obs_new, may_next;
      logic [31:0] tgt;
      ARREADY = ($urandom_range(0, 99) < ar_pct);
      case (rdy_mode)
         0:       inst_ready = 1'b0;
         1:       inst_ready = 1'b1;
         default: inst_ready = 1'($urandom_range(0, 1));
      endcase
      if (s_busy && s_dly == 0) begin
         RVALID = 1'b1; RLAST = 1'b1;
         RDATA  = slave_word(s_addr);
         RRESP  = (s_addr == err_addr) ? 2'b10 : 2'b00;
      end else begin
         RVALID = 1'b0; RLAST = 1'b0; RDATA = $urandom; RRESP = 2'b00;
         if (s_busy) s_dly--;
      end
      #1;
      redir_any = start | redir_valid;
      flush     = redir_any | hold_reset;
      tgt       = redir_valid ? redir_pc : entry_pc;
      obs_new   = ARVALID && !m_ar_pend;
      chk1("ar_issue", obs_new, m_may);
      if (obs_new) begin
         chk32("araddr", ARADDR, (dram_base + mpc) & 32'hFFFF_FFFC);
         m_ar_pend = 1; m_ar_addr = ARADDR; m_ar_pc = mpc; m_doom = 0; m_out = 1;
         ar_log.push_back(ARADDR);
      end else if (m_ar_pend) begin
         chk1("ar_stable_valid", ARVALID, 1'b1);
         chk32("ar_stable_addr", ARADDR, m_ar_addr);
      end
      chk1("rready", RREADY, m_out && !m_ar_pend);
      chk1("inst_valid", inst_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk32("inst_pc", inst_pc, mq[0].pc);
         chk32("inst_data", inst_data, mq[0].data);
         chk1("inst_err", inst_err, mq[0].err);
      end
      chk32("last_pc", last_pc, mlast);
      may_next = m_run && !flush && !m_halt && !m_out && (mq.size() < QDEPTH);
      ar_hs = ARVALID && ARREADY;
      r_hs  = RVALID && RREADY;
      pop   = inst_valid && inst_ready;
      if (pop && mq.size() != 0) begin
         mlast = mq[0].pc;
         pop_pc.push_back(inst_pc);
         pop_data.push_back(inst_data);
         void'(mq.pop_front());
      end
      if (ar_hs) begin
         ar_cnt++;
         m_ar_pend = 0;
         if (!m_doom && !flush) mpc = mpc + 32'd4;
         s_busy = 1; s_addr = ARADDR; s_dly = $urandom_range(r_lo, r_hi);
      end
      if (r_hs) begin
         m_out = 0; s_busy = 0;
         if (!m_doom && !flush) begin
            mq.push_back('{pc: m_ar_pc, data: RDATA, err: (RRESP != 2'b00)});
            if (RRESP != 2'b00) m_halt = 1;
         end
      end
      if (flush) begin
         mq.delete();
         m_halt = 0;
         if (m_out) m_doom = 1;
      end
      if (redir_any) mpc = tgt;
      if (hold_reset) m_run = 0;
      else if (redir_any) m_run = 1;
      m_may = may_next;
      @(posedge ACLK);
      @(negedge ACLK);
      start = 1'b0;
      redir_valid = 1'b0;
   endtask

   task automatic quiesce();
      hold_reset = 1'b1;
      tick();
      for (int i = 0; i < 40 && m_out; i++) tick();
      chk1("quiesce_rready", RREADY, 1'b0);
      hold_reset = 1'b0;
   endtask

   initial begin
      int hc;
      int r;
      ARESETN = 1'b0; start = 1'b0; hold_reset = 1'b0; redir_valid = 1'b0;
      dram_base = 32'h2000_0000; entry_pc = 32'd0; redir_pc = 32'd0;
      ARREADY = 1'b0; RDATA = 32'd0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
      inst_ready = 1'b0; ar_pct = 100; rdy_mode = 1; r_lo = 0; r_hi = 2;
      err_addr = 32'hFFFF_FFFF; ar_cnt = 0; s_dly = 0; s_addr = 0;
      model_reset();
      repeat (2) @(negedge ACLK);
      check_reset_outputs("rst");
      ARESETN = 1'b1;

      ar_pct = 50; rdy_mode = 2;
      repeat (10) begin
         tick();
         chk1("no_ar_after_rst", ARVALID, 1'b0);
      end

      // In-order fetch of the eight seeded words
      ar_pct = 100; rdy_mode = 1;
      pop_pc.delete(); pop_data.delete(); ar_log.delete();
      start = 1'b1;
      tick();
      for (int i = 0; i < 200 && pop_data.size() < 8; i++) tick();
      chk32("seq_count", 32'(pop_data.size()), 32'd8);
      if (pop_data.size() >= 8) begin
         for (int i = 0; i < 8; i++) begin
            chk32("seq_data", pop_data[i], 32'h11 + 32'(i));
            chk32("seq_pc", pop_pc[i], 32'(4 * i));
            chk32("seq_araddr", ar_log[i], 32'h2000_0000 + 32'(4 * i));
         end
         chk32("seq_last_pc", last_pc, 32'h1C);
      end

      // Back-pressure: queue fills, then no more requests
      quiesce();
      rdy_mode = 0; ar_cnt = 0;
      start = 1'b1;
      tick();
      repeat (49) tick();
      chk32("full_ar_count", 32'(ar_cnt), 32'(QDEPTH));
      chk1("full_arvalid", ARVALID, 1'b0);
      chk1("full_inst_valid", inst_valid, 1'b1);
      rdy_mode = 1;
      tick();
      for (int i = 0; i < 10 && !ARVALID; i++) tick();
      chk1("refill_after_pop", ARVALID, 1'b1);

      // Redirect while a read is in DATA with two entries queued
      quiesce();
      rdy_mode = 0; r_lo = 3; r_hi = 3;
      start = 1'b1;
      tick();
      for (int i = 0; i < 100 && !(mq.size() == 2 && m_out && !m_ar_pend); i++) tick();
      chk1("data_with_2_rready", RREADY, 1'b1);
      chk1("data_with_2_valid", inst_valid, 1'b1);
      redir_valid = 1'b1; redir_pc = 32'h100;
      tick();
      chk1("redir_flush", inst_valid, 1'b0);
      r_lo = 0; r_hi = 2; rdy_mode = 1;
      pop_pc.delete(); pop_data.delete();
      for (int i = 0; i < 50 && !ARVALID; i++) tick();
      chk32("redir_araddr", ARADDR, 32'h2000_0100);
      for (int i = 0; i < 50 && pop_pc.size() == 0; i++) tick();
      chk32("redir_first_pc", (pop_pc.size() != 0) ? pop_pc[0] : 32'hDEAD_DEAD, 32'h100);
      chk32("redir_first_data", (pop_data.size() != 0) ? pop_data[0] : 32'hDEAD_DEAD,
            32'h2000_0100 ^ 32'h5A5A_5A5A);

      // Error response halts fetch until a redirect
      quiesce();
      err_addr = 32'h2000_0008;
      start = 1'b1;
      tick();
      for (int i = 0; i < 100 && !(inst_valid && inst_err); i++) tick();
      chk1("err_flag", inst_err, 1'b1);
      chk32("err_pc", inst_pc, 32'h8);
      repeat (20) begin
         tick();
         chk1("halt_no_ar", ARVALID, 1'b0);
      end
      err_addr = 32'hFFFF_FFFF;
      redir_valid = 1'b1; redir_pc = 32'h40;
      tick();
      for (int i = 0; i < 20 && !ARVALID; i++) tick();
      chk32("halt_redir_araddr", ARADDR, 32'h2000_0040);

      // Randomized start / redirect / hold traffic
      quiesce();
      dram_base = $urandom & 32'hFFFF_F000;
      err_addr  = dram_base + 32'h40;
      ar_pct = 60; rdy_mode = 2; r_lo = 0; r_hi = 4; hc = 0;
      repeat (1500) begin
         r = $urandom_range(0, 99);
         if (hc > 0) hc--;
         else if (r < 2) hc = $urandom_range(1, 6);
         hold_reset = (hc > 0);
         if (r >= 2 && r < 5) begin
            start = 1'b1;
            entry_pc = $urandom & 32'hFF;
         end
         if (r >= 4 && r < 8) begin
            redir_valid = 1'b1;
            redir_pc = $urandom & 32'hFFF;
         end
         tick();
      end
      hold_reset = 1'b0;

      // Asynchronous reset while a request is pending
      dram_base = 32'h2000_0000; entry_pc = 32'd0; ar_pct = 50;
      start = 1'b1;
      tick();
      for (int i = 0; i < 50 && !ARVALID; i++) tick();
      chk1("arvalid_before_rst", ARVALID, 1'b1);
      #2 ARESETN = 1'b0;
      #1 check_reset_outputs("async_rst");
      RVALID = 1'b0; s_busy = 0;
      @(posedge ACLK);
      @(negedge ACLK);
      check_reset_outputs("rst_held");
      ARESETN = 1'b1;
      model_reset();
      repeat (20) begin
         tick();
         chk1("no_ar_post_rst", ARVALID, 1'b0);
      end
      start = 1'b1;
      tick();
      tick();
      chk1("ar_after_start", ARVALID, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
